// File: rtl/cic_compensator.sv
// Sequential-MAC FIR compensating CIC droop: one tap per clock, AHB-programmable
// coefficients, rounded and saturated AXI-Stream output.
module cic_compensator #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned TAPS  = 16,
  parameter int unsigned SHIFT = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic [DW-1:0] tdata_s,
  input  logic          tvalid_s,
  output logic          tready_s,
  output logic [DW-1:0] tdata_m,
  output logic          tvalid_m,
  input  logic          tready_m,
  input  logic [31:0]   haddr_s,
  input  logic [2:0]    hburst_s,
  input  logic [2:0]    hsize_s,
  input  logic [1:0]    htrans_s,
  input  logic [31:0]   hwdata_s,
  input  logic          hwrite_s,
  output logic [31:0]   hrdata_s,
  output logic          hreadyout_s,
  output logic          hresp_s,
  input  logic          hsel_s
);
  localparam int unsigned IW = $clog2(TAPS);
  localparam int unsigned PW = DW + CW;
  localparam int unsigned AW = PW + IW;
  localparam logic signed [AW-1:0] RND  = AW'(64'd1 << (SHIFT - 1));
  localparam logic signed [AW-1:0] OMAX = AW'((64'd1 << (DW - 1)) - 64'd1);
  localparam logic signed [AW-1:0] OMIN = ~OMAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;
  state_t state, state_nxt;

  logic signed [DW-1:0] xline [TAPS];
  logic signed [CW-1:0] coef  [TAPS];
  logic signed [AW-1:0] acc, acc_sum;
  logic signed [PW-1:0] prod;
  logic signed [DW-1:0] x_cur;
  logic signed [CW-1:0] c_cur, rd_coef;
  logic [IW-1:0]        idx;
  logic [DW-1:0]        mac_out;
  logic                 ctrl_en, ctrl_byp, armed, in_hs;
  logic                 dp_wr, addr_ph, stall;
  logic [11:2]          dp_addr;
  logic [31:0]          rd_data;
  logic                 unused_ok;

  assign unused_ok = ^{haddr_s[31:12], haddr_s[1:0], hburst_s, hsize_s, htrans_s[0],
                       hwdata_s[31:CW]};

  function automatic logic coef_hit(input logic [11:2] wa);
    return (wa[11:8] == 4'h1) && ({2'b00, wa[7:2]} < 8'(TAPS));
  endfunction

  function automatic logic [DW-1:0] sat_round(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] r;
    r = (a + RND) >>> SHIFT;
    if (r > OMAX) return DW'(OMAX);
    if (r < OMIN) return DW'(OMIN);
    return DW'(r);
  endfunction

  // armed keeps tready_s low until the first edge after reset release
  assign tready_s = ce && ctrl_en && armed && (state == S_IDLE);
  assign in_hs    = tvalid_s && tready_s;

  assign x_cur   = xline[idx];
  assign c_cur   = coef[idx];
  assign prod    = $signed({{CW{x_cur[DW-1]}}, x_cur}) * $signed({{DW{c_cur[CW-1]}}, c_cur});
  assign acc_sum = acc + {{IW{prod[PW-1]}}, prod};
  assign mac_out = sat_round(acc_sum);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ce) begin
      case (state)
        S_IDLE:  if (in_hs) state_nxt = ctrl_byp ? S_OUT : S_MAC;
        S_MAC:   if (idx == IW'(TAPS - 1)) state_nxt = S_OUT;
        S_OUT:   if (tready_m) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: delay line, accumulator and output register, all frozen by ce
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TAPS; k++) xline[k] <= '0;
      acc      <= '0;
      idx      <= '0;
      tdata_m  <= '0;
      tvalid_m <= 1'b0;
      armed    <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (ce) begin
        case (state)
          S_IDLE: begin
            if (in_hs && ctrl_byp) begin
              tdata_m  <= tdata_s;
              tvalid_m <= 1'b1;
            end else if (in_hs) begin
              xline[0] <= tdata_s;
              for (int k = 1; k < TAPS; k++) xline[k] <= xline[k-1];
              acc <= '0;
              idx <= '0;
            end
          end
          S_MAC: begin
            acc <= acc_sum;
            idx <= idx + IW'(1);
            if (idx == IW'(TAPS - 1)) begin
              tdata_m  <= mac_out;
              tvalid_m <= 1'b1;
            end
          end
          S_OUT:   if (tready_m) tvalid_m <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // A COEF write must not disturb an in-flight MAC, so its data phase waits for IDLE
  assign addr_ph     = hsel_s && htrans_s[1] && hreadyout_s;
  assign stall       = dp_wr && coef_hit(dp_addr) && (state != S_IDLE);
  assign hreadyout_s = !stall;
  assign hresp_s     = 1'b0;
  assign rd_coef     = coef[haddr_s[IW+1:2]];

  always_comb begin
    rd_data = '0;
    if (haddr_s[11:2] == 10'h000)      rd_data = {30'b0, ctrl_byp, ctrl_en};
    else if (haddr_s[11:2] == 10'h001) rd_data = {30'b0, tvalid_m, state != S_IDLE};
    else if (coef_hit(haddr_s[11:2]))  rd_data = {{(32-CW){rd_coef[CW-1]}}, rd_coef};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k < TAPS; k++) coef[k] <= '0;
      coef[0]  <= {1'b0, {(CW-1){1'b1}}};
      ctrl_en  <= 1'b1;
      ctrl_byp <= 1'b0;
      dp_wr    <= 1'b0;
      dp_addr  <= '0;
      hrdata_s <= '0;
    end else if (!stall) begin
      if (dp_wr && dp_addr == 10'h000) begin
        ctrl_en  <= hwdata_s[0];
        ctrl_byp <= hwdata_s[1];
      end else if (dp_wr && coef_hit(dp_addr)) begin
        coef[dp_addr[IW+1:2]] <= hwdata_s[CW-1:0];
      end
      dp_wr    <= addr_ph && hwrite_s;
      dp_addr  <= haddr_s[11:2];
      hrdata_s <= (addr_ph && !hwrite_s) ? rd_data : '0;
    end
  end
endmodule

// File: doc/cic_compensator.md
Name: cic_compensator

Overview:
- Sequential-MAC FIR that corrects the sinc droop of the CIC decimator. It sits directly downstream of the decimator and upstream of the stream hub in the DSP subsystem.
- Consumes the decimated 16-bit AXI-Stream, runs one tap per clock against AHB-programmable coefficients, and emits a rounded, saturated 16-bit stream.
- Decoded at AHB slot 0x0002_xxxx of the subsystem slave mux.

Parameters:
- DW, 16: signed sample width, input and output.
- CW, 16: signed coefficient width, Q1.(CW-1).
- TAPS, 16: number of taps, power of 2, range 4..64.
- SHIFT, 15: right-shift applied to the accumulator before saturation.

Ports:
- clk  in  1  subsystem clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; low freezes the datapath and FSM
- tdata_s  in  DW  input sample, signed
- tvalid_s  in  1  input valid
- tready_s  out  1  input ready
- tdata_m  out  DW  output sample, signed
- tvalid_m  out  1  output valid
- tready_m  in  1  output ready
- haddr_s  in  32  AHB address; bits [11:0] decoded
- hburst_s  in  3  ignored
- hsize_s  in  3  ignored; all accesses are treated as 32-bit
- htrans_s  in  2  AHB transfer type
- hwdata_s  in  32  AHB write data
- hwrite_s  in  1  AHB write
- hrdata_s  out  32  AHB read data
- hreadyout_s  out  1  AHB ready
- hresp_s  out  1  AHB response; always 0 (OKAY)
- hsel_s  in  1  slave select

Behaviour:
- Clocking and reset: single clock clk. reset_n is asynchronous, active-low.
- Reset values:
  - tready_s=0, tvalid_m=0, tdata_m=0, hrdata_s=0, hreadyout_s=1, hresp_s=0.
  - Delay line and accumulator are cleared.
  - CTRL = 0x1 (enable=1, bypass=0).
  - Coefficients: c[0]=0x7FFF, all others 0 (near-identity).
- Register map (word offsets):
  - 0x000 CTRL: [0] enable, [1] bypass. Read/write.
  - 0x004 STATUS: [0] busy (FSM not IDLE), [1] tvalid_m. Read-only.
  - 0x100+4k COEF[k], k<TAPS: writes take [CW-1:0]; reads return the value sign-extended to 32 bits.
  - Unmapped addresses read 0; writes to them are ignored.
- AHB protocol:
  - Address phase is captured when hsel_s & htrans_s[1] & hreadyout_s.
  - Write data is applied in the following data phase; read data is valid in the data phase.
  - Zero wait states, with one exception: a COEF write whose data phase occurs while FSM≠IDLE holds hreadyout_s=0 until the FSM returns to IDLE, then commits and raises hreadyout_s.
  - CTRL writes never stall. Writes to CTRL and COEF are unaffected by ce.
- FSM states: IDLE, MAC, OUT.
  - IDLE: tready_s = ce & enable.
    - On tvalid_s & tready_s with bypass=0: shift the sample into the delay line (x[0]=new, x[k]=x[k-1]), clear acc, go to MAC.
    - On the same handshake with bypass=1: tdata_m = sample, go to OUT. Bypass latency is 1 cycle.
  - MAC: each ce cycle, acc += x[i]*c[i], i=0..TAPS-1; after TAPS cycles go to OUT.
  - OUT: tvalid_m=1 and tdata_m is held stable until tready_m. On the handshake drop tvalid_m and go to IDLE. tready_s=0 throughout.
- Latency and throughput (bypass=0, ce=1, tready_m=1): tvalid_m rises TAPS+1 cycles after the input handshake. Throughput is one sample per TAPS+2 cycles.
- Arithmetic:
  - Products are DW+CW bits; acc is DW+CW+log2(TAPS) bits, signed.
  - Output = sat_DW((acc + (1<<(SHIFT-1))) >>> SHIFT), saturating to [-2^(DW-1), 2^(DW-1)-1].
- ce=0 freezes state, delay line, acc and outputs; tready_s is forced to 0.
- Clearing enable mid-operation lets the in-flight sample finish; no new sample is accepted afterwards.
- Bypass changes take effect at the next IDLE acceptance.
- Asserting reset_n low mid-MAC or mid-OUT drops the in-flight sample; all state returns to reset values immediately.

Test Plan:
- Impulse response: COEF[k]=0x0100*(k+1); input 0x7FFF, then 0x0000 samples → outputs 256, 512, …, 4096 (16 samples), then 0.
- Saturation:
  - All COEF=0x7FFF, 16× input 0x7FFF → 16th output 0x7FFF (saturated).
  - Then 16× input 0x8000 → 16th output 0x8000.
- Backpressure: hold tready_m=0 for 10 cycles in OUT → tdata_m stable, tready_s=0, STATUS=0x3. Release → exactly one handshake, no sample lost or duplicated.
- Coefficient write during MAC → hreadyout_s=0 until IDLE, then the write commits. Read COEF back: 0xFFFF8000 for a write of 0x8000.
- Bypass: CTRL=0x3; input 0x1234 → tdata_m=0x1234 with tvalid_m one cycle after the handshake. CTRL=0x0 → tready_s stays 0.
- Reset: assert reset_n low at MAC cycle 5 → tvalid_m=0, CTRL reads 0x1, COEF[0] reads 0x7FFF; the next impulse input 0x4000 produces output 0x4000.
